// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width, bubble
// encoding and FSM state encodings.
package instruction_fetch_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load captures a fetched
// instruction, otherwise the slot holds.
module if_id_reg
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = instruction_fetch_unit_pkg::NOP_INSTR
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] instr_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pc4_d,
    output logic [XLEN-1:0] instr_q,
    output logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] pc4_q,
    output logic            valid_q
);

    // The PC fields of a bubble are left as they were; only valid and the
    // instruction word mark the slot as empty.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load) begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control FSM and the
// IF/ID register feeding decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              IMEM_WORDS = 1024,
    parameter logic [XLEN-1:0] NOP_INSTR  = instruction_fetch_unit_pkg::NOP_INSTR
) (
    input  logic            CLK,
    input  logic            rst,
    output logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] RD,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            halt_i,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic            if_id_valid_o,
    output logic            fault_o,
    output logic [1:0]      state_o
);

    localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_WORDS);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4;
    logic            pc_oob;
    logic            redirect_misaligned;
    logic            ifid_load;
    logic            ifid_flush;

    assign A        = pc_q;
    assign state_o  = state_q;
    assign pc_plus4 = pc_q + INSTR_BYTES;

    // Word index compared against the memory depth; bits [1:0] are always 0.
    assign pc_oob              = {2'b00, pc_q[XLEN-1:2]} >= IMEM_LIMIT;
    assign redirect_misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (pc_oob || redirect_misaligned || halt_i || redirect_i)
                    ifid_flush = 1'b1;
                else if (!stall_i)
                    ifid_load = 1'b1;
            end
            ST_HALT: ifid_flush = 1'b1;
            default: ;
        endcase
    end

    // Priority in RUN: fault, halt, redirect, stall, then sequential fetch.
    always_ff @(posedge CLK or negedge rst) begin
        // NOTE: all state updates use non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            pc_q    <= RESET_PC;
            fault_o <= 1'b0;
            state_q <= ST_BOOT;
        end else begin
            case (state_q)
                ST_BOOT: state_q <= ST_RUN;
                ST_RUN: begin
                    if (pc_oob || redirect_misaligned) begin
                        fault_o <= 1'b1;
                        state_q <= ST_HALT;
                    end else if (halt_i) begin
                        state_q <= ST_HALT;
                    end else if (redirect_i) begin
                        pc_q <= redirect_pc_i;
                    end else if (!stall_i) begin
                        pc_q <= pc_plus4;
                    end
                end
                ST_HALT: ;
                default: state_q <= ST_HALT;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .CLK     (CLK),
        .rst     (rst),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .instr_d (RD),
        .pc_d    (pc_q),
        .pc4_d   (pc_plus4),
        .instr_q (if_id_instr_o),
        .pc_q    (if_id_pc_o),
        .pc4_q   (if_id_pc4_o),
        .valid_q (if_id_valid_o)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: table-driven vectors on a default
// instance plus short sequences for the small-memory and PC-wrap instances.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        halt;
        logic [31:0] a;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        fault;
        logic [1:0]  state;
    } vec_t;

    logic        CLK = 1'b0;
    logic        rst = 1'b0, rst4 = 1'b0, rstw = 1'b0;
    logic        stall = 1'b0, redirect = 1'b0, halt = 1'b0;
    logic [31:0] rpc = '0;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = '0;

    logic [31:0] A, RD, instr, pc, pc4;
    logic        valid, fault;
    logic [1:0]  state;
    logic [31:0] A4, RD4, instr4, pc4_4, pcp4_4;
    logic        valid4, fault4;
    logic [1:0]  state4;
    logic [31:0] Aw, RDw, instrw, pcw, pc4w;
    logic        validw, faultw;
    logic [1:0]  statew;

    int n_vec = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [5:0] idx);
        if (idx == 6'd0) return 32'h00B0_0080;
        if (idx == 6'd1) return 32'h0010_0093;
        return 32'hA000_0000 | {26'd0, idx};
    endfunction

    assign RD  = mem_word(A[7:2]);
    assign RD4 = mem_word(A4[7:2]);
    assign RDw = mem_word(Aw[7:2]);

    instruction_fetch_unit dut (
        .CLK(CLK), .rst(rst), .A(A), .RD(RD), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(rpc), .halt_i(halt), .if_id_instr_o(instr), .if_id_pc_o(pc),
        .if_id_pc4_o(pc4), .if_id_valid_o(valid), .fault_o(fault), .state_o(state)
    );

    instruction_fetch_unit #(.IMEM_WORDS(4)) dut4 (
        .CLK(CLK), .rst(rst4), .A(A4), .RD(RD4), .stall_i(zero_bit), .redirect_i(zero_bit),
        .redirect_pc_i(zero_word), .halt_i(zero_bit), .if_id_instr_o(instr4), .if_id_pc_o(pc4_4),
        .if_id_pc4_o(pcp4_4), .if_id_valid_o(valid4), .fault_o(fault4), .state_o(state4)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .IMEM_WORDS(32'h4000_0000)) dutw (
        .CLK(CLK), .rst(rstw), .A(Aw), .RD(RDw), .stall_i(zero_bit), .redirect_i(zero_bit),
        .redirect_pc_i(zero_word), .halt_i(zero_bit), .if_id_instr_o(instrw), .if_id_pc_o(pcw),
        .if_id_pc4_o(pc4w), .if_id_valid_o(validw), .fault_o(faultw), .state_o(statew)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rp,
                                input logic hl, input logic [31:0] ea, input logic [31:0] ei,
                                input logic [31:0] ep, input logic ev, input logic ef,
                                input logic [1:0] es);
        vec_t v;
        v.stall = st; v.redirect = rd; v.rpc = rp; v.halt = hl;
        v.a = ea; v.instr = ei; v.pc = ep; v.valid = ev; v.fault = ef; v.state = es;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        stall = v.stall; redirect = v.redirect; rpc = v.rpc; halt = v.halt;
        @(posedge CLK);
        #1;
        check({tag, ".A"},     A,     v.a);
        check({tag, ".instr"}, instr, v.instr);
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, v.valid});
        check({tag, ".fault"}, {31'd0, fault}, {31'd0, v.fault});
        check({tag, ".state"}, {30'd0, state}, {30'd0, v.state});
        if (v.valid) begin
            check({tag, ".pc"},  pc,  v.pc);
            check({tag, ".pc4"}, pc4, v.pc + 32'd4);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".A"},     A,     32'h0);
        check({tag, ".instr"}, instr, NOP);
        check({tag, ".pc"},    pc,    32'h0);
        check({tag, ".pc4"},   pc4,   32'h0);
        check({tag, ".valid"}, {31'd0, valid}, 32'd0);
        check({tag, ".fault"}, {31'd0, fault}, 32'd0);
        check({tag, ".state"}, {30'd0, state}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        vec_t va[14];
        vec_t vb[4];

        // Normal fetch, stall, redirect-over-stall, halt-over-redirect.
        va[0]  = mk(0, 0, 32'h00, 0, 32'h00, NOP,          32'h00, 0, 0, 2'd1);
        va[1]  = mk(0, 0, 32'h00, 0, 32'h04, 32'h00B00080, 32'h00, 1, 0, 2'd1);
        va[2]  = mk(0, 0, 32'h00, 0, 32'h08, 32'h00100093, 32'h04, 1, 0, 2'd1);
        va[3]  = mk(1, 0, 32'h00, 0, 32'h08, 32'h00100093, 32'h04, 1, 0, 2'd1);
        va[4]  = mk(1, 0, 32'h00, 0, 32'h08, 32'h00100093, 32'h04, 1, 0, 2'd1);
        va[5]  = mk(1, 0, 32'h00, 0, 32'h08, 32'h00100093, 32'h04, 1, 0, 2'd1);
        va[6]  = mk(0, 0, 32'h00, 0, 32'h0C, 32'hA0000002, 32'h08, 1, 0, 2'd1);
        va[7]  = mk(1, 1, 32'h1C, 0, 32'h1C, NOP,          32'h00, 0, 0, 2'd1);
        va[8]  = mk(0, 0, 32'h00, 0, 32'h20, 32'hA0000007, 32'h1C, 1, 0, 2'd1);
        va[9]  = mk(0, 0, 32'h00, 0, 32'h24, 32'hA0000008, 32'h20, 1, 0, 2'd1);
        va[10] = mk(0, 1, 32'h40, 0, 32'h40, NOP,          32'h00, 0, 0, 2'd1);
        va[11] = mk(0, 1, 32'h80, 1, 32'h40, NOP,          32'h00, 0, 0, 2'd2);
        va[12] = mk(0, 0, 32'h00, 0, 32'h40, NOP,          32'h00, 0, 0, 2'd2);
        va[13] = mk(1, 1, 32'h60, 0, 32'h40, NOP,          32'h00, 0, 0, 2'd2);

        // After reset from HALT: restart, then a misaligned redirect faults.
        vb[0] = mk(0, 0, 32'h00, 0, 32'h00, NOP,          32'h00, 0, 0, 2'd1);
        vb[1] = mk(0, 0, 32'h00, 0, 32'h04, 32'h00B00080, 32'h00, 1, 0, 2'd1);
        vb[2] = mk(0, 1, 32'h1E, 0, 32'h04, NOP,          32'h00, 0, 1, 2'd2);
        vb[3] = mk(0, 1, 32'h08, 0, 32'h04, NOP,          32'h00, 0, 1, 2'd2);

        #12;
        check_reset_values("rst0");
        @(negedge CLK);
        rst = 1'b1;
        for (int i = 0; i < 14; i++) apply(va[i], $sformatf("va%0d", i));

        // Asynchronous reset in the middle of a HALT cycle.
        stall = 1'b0; redirect = 1'b0; halt = 1'b0; rpc = '0;
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("rst_halt");
        @(negedge CLK);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) apply(vb[i], $sformatf("vb%0d", i));

        // IMEM_WORDS=4: four fetches, then an out-of-range fault at A=16.
        @(negedge CLK);
        rst4 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge CLK);
            #1;
            if (k == 0) begin
                check("m4.boot.A", A4, 32'h0);
                check("m4.boot.valid", {31'd0, valid4}, 32'd0);
            end else if (k <= 4) begin
                check($sformatf("m4.f%0d.instr", k), instr4, mem_word(6'(k - 1)));
                check($sformatf("m4.f%0d.pc", k), pc4_4, 32'(4 * (k - 1)));
                check($sformatf("m4.f%0d.valid", k), {31'd0, valid4}, 32'd1);
                check($sformatf("m4.f%0d.A", k), A4, 32'(4 * k));
            end else begin
                check($sformatf("m4.h%0d.A", k), A4, 32'd16);
                check($sformatf("m4.h%0d.fault", k), {31'd0, fault4}, 32'd1);
                check($sformatf("m4.h%0d.state", k), {30'd0, state4}, 32'd2);
                check($sformatf("m4.h%0d.valid", k), {31'd0, valid4}, 32'd0);
                check($sformatf("m4.h%0d.instr", k), instr4, NOP);
            end
        end

        // PC wraps from 32'hFFFFFFFC to 0, and so does the captured pc+4.
        @(negedge CLK);
        rstw = 1'b1;
        @(posedge CLK);
        #1;
        check("wrap.boot.A", Aw, 32'hFFFF_FFFC);
        @(posedge CLK);
        #1;
        check("wrap.f0.instr", instrw, mem_word(6'd63));
        check("wrap.f0.pc", pcw, 32'hFFFF_FFFC);
        check("wrap.f0.pc4", pc4w, 32'h0);
        check("wrap.f0.A", Aw, 32'h0);
        check("wrap.f0.valid", {31'd0, validw}, 32'd1);
        @(posedge CLK);
        #1;
        check("wrap.f1.instr", instrw, 32'h00B0_0080);
        check("wrap.f1.pc", pcw, 32'h0);
        check("wrap.f1.pc4", pc4w, 32'h4);
        check("wrap.f1.fault", {31'd0, faultw}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
